// File: rtl/uart_apb4_regfile.sv
// APB4 slave register file for the UART core.
// Holds CTRL, the IRQ mask and sticky W1C IRQ status, and bridges APB accesses to
// the downstream (DFIFO, push) and upstream (UFIFO, pop) FIFOs.
// Ports:
//   i_apb_*            APB4 slave request (pclk, presetn, paddr, psel, penable, pwrite, pwdata, pstrb)
//   o_apb_pready       access complete after WAIT_STATES+1 access-phase cycles (combinational)
//   o_apb_prdata       read data, zero unless pready and no error (combinational)
//   o_apb_pslverr      access error, valid with pready (combinational)
//   i_irq_pulse        one-cycle event pulses, OR'd into sticky status
//   i_stats            read-only status word from the core
//   i_dfifo_full       downstream FIFO full
//   o_dfifo_push/data  registered one-cycle push and its data
//   i_ufifo_empty/data upstream FIFO empty flag and show-ahead head word
//   o_ufifo_pop        registered one-cycle pop
//   o_ctrl             CTRL register contents
//   o_irq              registered level interrupt, |(status & mask)
module uart_apb4_regfile #(
  parameter int unsigned APB_ADDR_WIDTH  = 12,
  parameter int unsigned APB_DATA_WIDTH  = 32,
  parameter int unsigned IRQ_NUM         = 8,
  parameter int unsigned FIFO_DATA_WIDTH = 9,
  parameter int unsigned WAIT_STATES     = 1,
  parameter int unsigned BIT_LENGTH_RST  = 1000
) (
  input  logic                       i_apb_pclk,
  input  logic                       i_apb_presetn,
  input  logic [APB_ADDR_WIDTH-1:0]  i_apb_paddr,
  input  logic                       i_apb_psel,
  input  logic                       i_apb_penable,
  input  logic                       i_apb_pwrite,
  input  logic [APB_DATA_WIDTH-1:0]  i_apb_pwdata,
  input  logic [3:0]                 i_apb_pstrb,
  output logic                       o_apb_pready,
  output logic [APB_DATA_WIDTH-1:0]  o_apb_prdata,
  output logic                       o_apb_pslverr,
  input  logic [IRQ_NUM-1:0]         i_irq_pulse,
  input  logic [15:0]                i_stats,
  input  logic                       i_dfifo_full,
  output logic                       o_dfifo_push,
  output logic [FIFO_DATA_WIDTH-1:0] o_dfifo_data,
  input  logic                       i_ufifo_empty,
  input  logic [FIFO_DATA_WIDTH-1:0] i_ufifo_data,
  output logic                       o_ufifo_pop,
  output logic [31:0]                o_ctrl,
  output logic                       o_irq
);

  localparam int unsigned CTRL_W = 19;
  localparam int unsigned CNT_W  = 4;

  localparam logic [4:0] OFF_CTRL   = 5'h00;
  localparam logic [4:0] OFF_MASK   = 5'h04;
  localparam logic [4:0] OFF_STAT   = 5'h08;
  localparam logic [4:0] OFF_DFIFO  = 5'h0C;
  localparam logic [4:0] OFF_UFIFO  = 5'h10;
  localparam logic [4:0] OFF_STATS  = 5'h14;
  localparam logic [4:0] OFF_HWINFO = 5'h18;

  // Elaboration-time parameter range checks
  if (APB_DATA_WIDTH != 32) begin : g_bad_dw
    $error("uart_apb4_regfile: APB_DATA_WIDTH must be 32");
  end
  if (APB_ADDR_WIDTH < 6) begin : g_bad_aw
    $error("uart_apb4_regfile: APB_ADDR_WIDTH must be at least 6");
  end
  if (IRQ_NUM < 1 || IRQ_NUM > 16) begin : g_bad_irq
    $error("uart_apb4_regfile: IRQ_NUM must be 1..16");
  end
  if (FIFO_DATA_WIDTH < 1 || FIFO_DATA_WIDTH > 32) begin : g_bad_fw
    $error("uart_apb4_regfile: FIFO_DATA_WIDTH must be 1..32");
  end
  if (WAIT_STATES > 15) begin : g_bad_ws
    $error("uart_apb4_regfile: WAIT_STATES must be 0..15");
  end

  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic [CTRL_W-1:0]          ctrl_q, ctrl_d;
  logic [IRQ_NUM-1:0]         mask_q, mask_d;
  logic [IRQ_NUM-1:0]         stat_q, stat_d;
  logic                       irq_q, irq_d;
  logic                       push_q, push_d;
  logic [FIFO_DATA_WIDTH-1:0] dfifo_data_q, dfifo_data_d;
  logic                       pop_q, pop_d;

  logic        access_c, pready_c, err_c, wr_ok_c, rd_ok_c;
  logic [4:0]  off_c;
  logic        sel_ctrl_c, sel_mask_c, sel_stat_c, sel_dfifo_c;
  logic        sel_ufifo_c, sel_stats_c, sel_hwinfo_c;
  logic [31:0] wmask_c, rdata_c;

  // Address decode, error classification and wait-state handshake
  always_comb begin
    access_c     = i_apb_psel & i_apb_penable;
    pready_c     = access_c & (cnt_q == CNT_W'(WAIT_STATES));
    off_c        = i_apb_paddr[4:0];
    sel_ctrl_c   = (off_c == OFF_CTRL);
    sel_mask_c   = (off_c == OFF_MASK);
    sel_stat_c   = (off_c == OFF_STAT);
    sel_dfifo_c  = (off_c == OFF_DFIFO);
    sel_ufifo_c  = (off_c == OFF_UFIFO);
    sel_stats_c  = (off_c == OFF_STATS);
    sel_hwinfo_c = (off_c == OFF_HWINFO);
    wmask_c      = {{8{i_apb_pstrb[3]}}, {8{i_apb_pstrb[2]}},
                    {8{i_apb_pstrb[1]}}, {8{i_apb_pstrb[0]}}};
    err_c = (|i_apb_paddr[APB_ADDR_WIDTH-1:5])
          | (|off_c[1:0])
          | (off_c > OFF_HWINFO)
          | (i_apb_pwrite & (sel_ufifo_c | sel_stats_c | sel_hwinfo_c))
          | (!i_apb_pwrite & sel_dfifo_c)
          | (i_apb_pwrite & sel_dfifo_c & (i_dfifo_full | (i_apb_pstrb != 4'hF)))
          | (!i_apb_pwrite & sel_ufifo_c & i_ufifo_empty);
    wr_ok_c = pready_c & !err_c & i_apb_pwrite;
    rd_ok_c = pready_c & !err_c & !i_apb_pwrite;
  end

  // Read data mux
  always_comb begin
    rdata_c = '0;
    unique case (off_c)
      OFF_CTRL:   rdata_c = 32'(ctrl_q);
      OFF_MASK:   rdata_c = 32'(mask_q);
      OFF_STAT:   rdata_c = 32'(stat_q);
      OFF_UFIFO:  rdata_c = 32'(i_ufifo_data);
      OFF_STATS:  rdata_c = {16'h0, i_stats};
      OFF_HWINFO: rdata_c = {8'(IRQ_NUM), 8'(FIFO_DATA_WIDTH), 8'(WAIT_STATES), 8'h21};
      default:    rdata_c = '0;
    endcase
  end

  // Next-state for counter, registers, IRQ and FIFO strobes
  always_comb begin
    cnt_d        = '0;
    ctrl_d       = ctrl_q;
    mask_d       = mask_q;
    stat_d       = stat_q | i_irq_pulse;
    push_d       = 1'b0;
    dfifo_data_d = dfifo_data_q;
    pop_d        = 1'b0;

    if (access_c && !pready_c) begin
      cnt_d = CNT_W'(cnt_q + 1'b1);
    end
    if (wr_ok_c && sel_ctrl_c) begin
      ctrl_d = CTRL_W'((32'(ctrl_q) & ~wmask_c) | (i_apb_pwdata & wmask_c));
    end
    if (wr_ok_c && sel_mask_c) begin
      mask_d = IRQ_NUM'((32'(mask_q) & ~wmask_c) | (i_apb_pwdata & wmask_c));
    end
    // A pulse in the same cycle as its clear keeps the bit set
    if (wr_ok_c && sel_stat_c) begin
      stat_d = (stat_q & ~IRQ_NUM'(i_apb_pwdata & wmask_c)) | i_irq_pulse;
    end
    if (wr_ok_c && sel_dfifo_c) begin
      push_d       = 1'b1;
      dfifo_data_d = FIFO_DATA_WIDTH'(i_apb_pwdata);
    end
    if (rd_ok_c && sel_ufifo_c) begin
      pop_d = 1'b1;
    end
    irq_d = |(stat_d & mask_q);
  end

  // State registers
  always_ff @(posedge i_apb_pclk or negedge i_apb_presetn) begin
    if (!i_apb_presetn) begin
      cnt_q        <= '0;
      ctrl_q       <= {3'b000, 16'(BIT_LENGTH_RST)};
      mask_q       <= '0;
      stat_q       <= '0;
      irq_q        <= 1'b0;
      push_q       <= 1'b0;
      dfifo_data_q <= '0;
      pop_q        <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      ctrl_q       <= ctrl_d;
      mask_q       <= mask_d;
      stat_q       <= stat_d;
      irq_q        <= irq_d;
      push_q       <= push_d;
      dfifo_data_q <= dfifo_data_d;
      pop_q        <= pop_d;
    end
  end

  assign o_apb_pready  = pready_c;
  assign o_apb_pslverr = pready_c & err_c;
  assign o_apb_prdata  = (pready_c && !err_c) ? rdata_c : '0;
  assign o_dfifo_push  = push_q;
  assign o_dfifo_data  = dfifo_data_q;
  assign o_ufifo_pop   = pop_q;
  assign o_ctrl        = 32'(ctrl_q);
  assign o_irq         = irq_q;

endmodule
